rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Writeback arbiter for the dual-write-port 64-bit integer register file. It collects writeback requests from NREQ producers (ALU0, ALU1, LSU, MDU), grants at most two per cycle using round-robin priority, and drives the register file's two write buses from registered outputs. It guarantees the two write ports never target the same nonzero register in the same cycle.

Parameters:
NREQ, 4, number of writeback requesters (2..8)
XLEN, 64, data width
AW, 5, register address width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  requester i has a writeback pending
req_addr  input  NREQ*AW  destination register of requester i, slice [i*AW +: AW]
req_data  input  NREQ*XLEN  writeback data of requester i, slice [i*XLEN +: XLEN]
req_ready  output  NREQ  requester i granted this cycle (combinational)
rf_bus_0_wen  output  1  write enable, RF port 0
rf_bus_0_waddr  output  AW  write address, RF port 0
rf_bus_0_wdata  output  XLEN  write data, RF port 0
rf_bus_1_wen  output  1  write enable, RF port 1
rf_bus_1_waddr  output  AW  write address, RF port 1
rf_bus_1_wdata  output  XLEN  write data, RF port 1
rr_ptr  output  log2(NREQ)  current highest-priority requester (debug/DPI visibility)

Behaviour:
- Handshake: a transfer occurs when req_valid[i] && req_ready[i] at a rising clock edge. A requester holds valid, addr and data stable until it is granted. req_ready never asserts without req_valid.
- Selection is combinational and scans requesters circularly from rr_ptr: (rr_ptr, rr_ptr+1, ... mod NREQ).
  - slot0 is the first valid requester in scan order.
  - slot1 is the next valid requester in scan order whose addr differs from slot0's addr.
  - The x0 exception: when either address is 0, the address-difference rule does not apply.
  - A requester skipped by the collision rule stays pending and keeps req_ready=0.
- An x0 request (addr==0) consumes a slot and is acknowledged (req_ready=1). Its port wen is 0, and waddr/wdata still update.
- Latency is 1 cycle: a slot granted in cycle N appears on rf_bus_k_* in cycle N+1.
  - wen is high for exactly that one cycle unless it is re-granted.
  - slot0 maps to port 0 and slot1 maps to port 1.
  - A port with no grant has wen=0 and holds its previous waddr/wdata.
- rr_ptr update at each edge:
  - If there was any grant, rr_ptr = (index of the last granted slot + 1) mod NREQ. The last granted slot is slot1 if it exists, else slot0.
  - With no grants, rr_ptr is unchanged.
- Starvation freedom: any continuously valid requester is granted within NREQ cycles.
- Reset (synchronous; also applies mid-operation):
  - Next edge: rf_bus_*_wen=0, waddr=0, wdata=0, rr_ptr=0.
  - While reset is high, req_ready is forced to all-zero, so no handshake completes.
  - A request pending at reset is neither granted nor dropped by the arbiter; the requester re-presents it.
- Invariant: rf_bus_0_wen && rf_bus_1_wen implies rf_bus_0_waddr != rf_bus_1_waddr.
- All widths are fixed. There is no arithmetic other than the pointer increment modulo NREQ, which is valid for non-power-of-two NREQ.

Test Plan:
- Reset then idle: reset high 2 cycles, all valid=0 -> wen0=wen1=0, waddr=0, wdata=0, rr_ptr=0, req_ready=0000.
- Two distinct writes: rr_ptr=0, valid=0011, addr0=5 data=0xAA, addr1=7 data=0xBB -> req_ready=0011. Next cycle: port0 {1,5,0xAA}, port1 {1,7,0xBB}. rr_ptr becomes 2.
- Address collision: rr_ptr=0, valid=0111, addr0=3, addr1=3, addr2=9 -> req_ready=0101. Port0 gets x3 from req0, port1 gets x9 from req2, rr_ptr becomes 3. Next cycle req1 (x3) is granted alone on port0.
- x0 suppression: valid=0001, addr0=0, data=0x1234 -> req_ready=0001. Next cycle wen0=0, waddr0=0, wdata0=0x1234, wen1=0.
- Fairness: all four requesters held valid with distinct addresses for 4 cycles -> grants are {0,1}, {2,3}, {0,1}, {2,3}. Each requester gets ready once per 2 cycles, and no port ever writes the same address twice in one cycle.
- Reset mid-operation: valid=1111 with a grant in flight, assert reset for 1 cycle -> req_ready=0000 during reset. Next edge wen=0 and rr_ptr=0. After reset, grants restart from requester 0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Signal bundle between writeback producers, the writeback arbiter and the register file's two write ports.
interface rf_wb_arbiter_if #(
    parameter int NREQ = 4,
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_bus_0_wen;
    logic [AW-1:0]        rf_bus_0_waddr;
    logic [XLEN-1:0]      rf_bus_0_wdata;
    logic                 rf_bus_1_wen;
    logic [AW-1:0]        rf_bus_1_waddr;
    logic [XLEN-1:0]      rf_bus_1_wdata;

    modport master (
        input  req_valid, req_addr, req_data,
        output req_ready,
        output rf_bus_0_wen, rf_bus_0_waddr, rf_bus_0_wdata,
        output rf_bus_1_wen, rf_bus_1_waddr, rf_bus_1_wdata
    );

    modport slave (
        output req_valid, req_addr, req_data,
        input  req_ready,
        input  rf_bus_0_wen, rf_bus_0_waddr, rf_bus_0_wdata,
        input  rf_bus_1_wen, rf_bus_1_waddr, rf_bus_1_wdata
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter: grants up to two requesters per cycle onto the register file's
// two registered write ports, never letting both ports write the same nonzero register.
module rf_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    rf_wb_arbiter_if.master          bus,
    output logic [$clog2(NREQ)-1:0]  rr_ptr
);
    localparam int PW = $clog2(NREQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    logic [AW-1:0]   w_addr [NREQ];
    logic [XLEN-1:0] w_data [NREQ];

    logic [PW-1:0]   r_rrPtr;
    logic            r_wen0;
    logic [AW-1:0]   r_waddr0;
    logic [XLEN-1:0] r_wdata0;
    logic            r_wen1;
    logic [AW-1:0]   r_waddr1;
    logic [XLEN-1:0] r_wdata1;

    logic            w_slot0Found;
    logic            w_slot1Found;
    logic [PW-1:0]   w_slot0Idx;
    logic [PW-1:0]   w_slot1Idx;
    logic [PW-1:0]   w_scanIdx;
    logic [NREQ-1:0] w_ready;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr[g] = bus.req_addr[g*AW +: AW];
        assign w_data[g] = bus.req_data[g*XLEN +: XLEN];
    end

    function automatic logic [PW-1:0] nextIdx(input logic [PW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // Scan circularly from the pointer; slot1 skips anyone whose nonzero address collides with slot0's.
    always_comb begin
        w_slot0Found = 1'b0;
        w_slot1Found = 1'b0;
        w_slot0Idx   = '0;
        w_slot1Idx   = '0;
        w_scanIdx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scanIdx = PW'((int'(r_rrPtr) + k) % NREQ);
            if (bus.req_valid[w_scanIdx]) begin
                if (!w_slot0Found) begin
                    w_slot0Found = 1'b1;
                    w_slot0Idx   = w_scanIdx;
                end else if (!w_slot1Found &&
                             (w_addr[w_slot0Idx] == '0 || w_addr[w_scanIdx] == '0 ||
                              w_addr[w_scanIdx] != w_addr[w_slot0Idx])) begin
                    w_slot1Found = 1'b1;
                    w_slot1Idx   = w_scanIdx;
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (!reset) begin
            if (w_slot0Found) w_ready[w_slot0Idx] = 1'b1;
            if (w_slot1Found) w_ready[w_slot1Idx] = 1'b1;
        end
    end

    // Writes to x0 still take a port and update its address/data, but never raise wen.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rrPtr  <= '0;
            r_wen0   <= 1'b0;
            r_waddr0 <= '0;
            r_wdata0 <= '0;
            r_wen1   <= 1'b0;
            r_waddr1 <= '0;
            r_wdata1 <= '0;
        end else begin
            r_wen0 <= w_slot0Found && (w_addr[w_slot0Idx] != '0);
            r_wen1 <= w_slot1Found && (w_addr[w_slot1Idx] != '0);
            if (w_slot0Found) begin
                r_waddr0 <= w_addr[w_slot0Idx];
                r_wdata0 <= w_data[w_slot0Idx];
            end
            if (w_slot1Found) begin
                r_waddr1 <= w_addr[w_slot1Idx];
                r_wdata1 <= w_data[w_slot1Idx];
            end
            if (w_slot1Found) begin
                r_rrPtr <= nextIdx(w_slot1Idx);
            end else if (w_slot0Found) begin
                r_rrPtr <= nextIdx(w_slot0Idx);
            end
        end
    end

    assign bus.req_ready      = w_ready;
    assign bus.rf_bus_0_wen   = r_wen0;
    assign bus.rf_bus_0_waddr = r_waddr0;
    assign bus.rf_bus_0_wdata = r_wdata0;
    assign bus.rf_bus_1_wen   = r_wen1;
    assign bus.rf_bus_1_waddr = r_waddr1;
    assign bus.rf_bus_1_wdata = r_wdata1;
    assign rr_ptr             = r_rrPtr;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized bench for rf_wb_arbiter; a queue-based reference model predicts
// grants, port contents and the round-robin pointer each cycle.
module tb_rf_wb_arbiter;
    localparam int NREQ = 4;
    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] rrPtr;
    int         testCount = 0;
    int         failCount = 0;

    rf_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();

    rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .rr_ptr (rrPtr)
    );

    always #5 clock = ~clock;

    // Requester side: 0 = drop request once granted, 1 = keep it valid forever, 2 = random refill.
    logic            reqValid [NREQ];
    logic [AW-1:0]   reqAddr  [NREQ];
    logic [XLEN-1:0] reqData  [NREQ];
    int              reqMode;

    int              modelPtr;
    logic            expWen  [2];
    logic [AW-1:0]   expAddr [2];
    logic [XLEN-1:0] expData [2];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: list the valid requesters in priority order, take the first, then the first later one allowed to pair with it.
    function automatic void pickSlots(output int s0, output int s1);
        int order[$];
        s0 = -1;
        s1 = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (reqValid[(modelPtr + k) % NREQ]) order.push_back((modelPtr + k) % NREQ);
        end
        if (order.size() > 0) s0 = order[0];
        for (int j = 1; j < order.size(); j++) begin
            if (s1 < 0 && (reqAddr[s0] == 0 || reqAddr[order[j]] == 0 || reqAddr[order[j]] != reqAddr[s0]))
                s1 = order[j];
        end
    endfunction

    task automatic newRandom(input int i);
        reqValid[i] = 1'b1;
        reqAddr[i]  = AW'($urandom_range(0, 7));
        reqData[i]  = {$urandom, $urandom};
    endtask

    task automatic clearAll();
        for (int i = 0; i < NREQ; i++) begin
            reqValid[i] = 1'b0;
            reqAddr[i]  = '0;
            reqData[i]  = '0;
        end
    endtask

    task automatic applyStimulus(input logic rst);
        int              s0;
        int              s1;
        int              sl;
        logic [NREQ-1:0] expReady;
        reset = rst;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]             = reqValid[i];
            bus.req_addr[i*AW +: AW]     = reqAddr[i];
            bus.req_data[i*XLEN +: XLEN] = reqData[i];
        end
        #1;
        pickSlots(s0, s1);
        expReady = '0;
        if (!rst) begin
            if (s0 >= 0) expReady[s0] = 1'b1;
            if (s1 >= 0) expReady[s1] = 1'b1;
        end
        checkOutput("req_ready", 64'(bus.req_ready), 64'(expReady));
        @(posedge clock);
        if (rst) begin
            modelPtr = 0;
            for (int p = 0; p < 2; p++) begin
                expWen[p]  = 1'b0;
                expAddr[p] = '0;
                expData[p] = '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                sl = (p == 0) ? s0 : s1;
                if (sl >= 0) begin
                    expWen[p]  = (reqAddr[sl] != 0);
                    expAddr[p] = reqAddr[sl];
                    expData[p] = reqData[sl];
                end else begin
                    expWen[p] = 1'b0;
                end
            end
            if (s1 >= 0) modelPtr = (s1 + 1) % NREQ;
            else if (s0 >= 0) modelPtr = (s0 + 1) % NREQ;
        end
        #1;
        checkOutput("wen0",   64'(bus.rf_bus_0_wen),   64'(expWen[0]));
        checkOutput("waddr0", 64'(bus.rf_bus_0_waddr), 64'(expAddr[0]));
        checkOutput("wdata0", bus.rf_bus_0_wdata,      expData[0]);
        checkOutput("wen1",   64'(bus.rf_bus_1_wen),   64'(expWen[1]));
        checkOutput("waddr1", 64'(bus.rf_bus_1_waddr), 64'(expAddr[1]));
        checkOutput("wdata1", bus.rf_bus_1_wdata,      expData[1]);
        checkOutput("rr_ptr", 64'(rrPtr),              64'(modelPtr));
        checkOutput("port_collision",
                    64'(bus.rf_bus_0_wen && bus.rf_bus_1_wen && bus.rf_bus_0_waddr == bus.rf_bus_1_waddr),
                    64'(0));
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (expReady[i] && reqMode == 0) reqValid[i] = 1'b0;
                if (expReady[i] && reqMode == 2) begin
                    if ($urandom_range(0, 2) != 0) newRandom(i);
                    else reqValid[i] = 1'b0;
                end else if (!reqValid[i] && reqMode == 2 && $urandom_range(0, 1) == 1) begin
                    newRandom(i);
                end
            end
        end
        @(negedge clock);
    endtask

    initial begin
        modelPtr = 0;
        for (int p = 0; p < 2; p++) begin
            expWen[p]  = 1'b0;
            expAddr[p] = '0;
            expData[p] = '0;
        end
        reqMode = 0;
        clearAll();

        // Reset then idle
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("plan_reset_ptr",   64'(rrPtr), 64'(0));
        checkOutput("plan_reset_wdata", bus.rf_bus_0_wdata, 64'(0));

        // Two distinct writes
        reqValid[0] = 1'b1; reqAddr[0] = 5'd5; reqData[0] = 64'hAA;
        reqValid[1] = 1'b1; reqAddr[1] = 5'd7; reqData[1] = 64'hBB;
        applyStimulus(1'b0);
        checkOutput("plan_two_ptr",   64'(rrPtr), 64'(2));
        checkOutput("plan_two_data1", bus.rf_bus_1_wdata, 64'hBB);

        // Address collision, starting again from pointer 0
        clearAll();
        applyStimulus(1'b1);
        reqValid[0] = 1'b1; reqAddr[0] = 5'd3; reqData[0] = 64'h30;
        reqValid[1] = 1'b1; reqAddr[1] = 5'd3; reqData[1] = 64'h31;
        reqValid[2] = 1'b1; reqAddr[2] = 5'd9; reqData[2] = 64'h92;
        applyStimulus(1'b0);
        checkOutput("plan_coll_addr1", 64'(bus.rf_bus_1_waddr), 64'(9));
        checkOutput("plan_coll_ptr",   64'(rrPtr), 64'(3));
        applyStimulus(1'b0);
        checkOutput("plan_coll_late_data0", bus.rf_bus_0_wdata, 64'h31);

        // x0 write consumes a slot without enabling the port
        reqValid[0] = 1'b1; reqAddr[0] = 5'd0; reqData[0] = 64'h1234;
        applyStimulus(1'b0);
        checkOutput("plan_x0_wen0",   64'(bus.rf_bus_0_wen), 64'(0));
        checkOutput("plan_x0_wdata0", bus.rf_bus_0_wdata, 64'h1234);

        // Fairness with all four held valid, then reset mid-operation
        clearAll();
        applyStimulus(1'b1);
        reqMode = 1;
        for (int i = 0; i < NREQ; i++) begin
            reqValid[i] = 1'b1;
            reqAddr[i]  = AW'(i + 1);
            reqData[i]  = 64'(16 * (i + 1));
        end
        for (int c = 0; c < 4; c++) applyStimulus(1'b0);
        checkOutput("plan_fair_ptr", 64'(rrPtr), 64'(0));
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("plan_midreset_ptr", 64'(rrPtr), 64'(0));
        applyStimulus(1'b0);
        checkOutput("plan_restart_addr0", 64'(bus.rf_bus_0_waddr), 64'(1));

        // Randomized traffic with occasional resets
        reqMode = 2;
        clearAll();
        for (int c = 0; c < 400; c++) applyStimulus($urandom_range(0, 49) == 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
